// File: rtl/sfu_acc_buf_pkg.sv
// rtl/sfu_acc_buf_pkg.sv - shared encodings for the accumulating output SFU
package sfu_acc_buf_pkg;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_LEAKY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACC   = 2'b01,
        S_DRAIN = 2'b10
    } sfu_state_t;

endpackage

// File: rtl/sfu_acc_buf_lane_alu.sv
// rtl/sfu_acc_buf_lane_alu.sv - per-lane saturating add and drain-side activation
module sfu_lane_alu
    import sfu_acc_buf_pkg::*;
#(
    parameter int psum_bw     = 16,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic [psum_bw-1:0] acc_a,
    input  logic [psum_bw-1:0] add_b,
    input  logic [psum_bw-1:0] act_in,
    input  logic [1:0]         mode,
    output logic [psum_bw-1:0] sum_out,
    output logic               sat,
    output logic [psum_bw-1:0] act_out
);

    logic [psum_bw:0] ext_sum;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    always_comb begin
        ext_sum = {acc_a[psum_bw-1], acc_a} + {add_b[psum_bw-1], add_b};
        sat     = ext_sum[psum_bw] ^ ext_sum[psum_bw-1];
        sum_out = ext_sum[psum_bw-1:0];
        if (sat) begin
            if (ext_sum[psum_bw])
                sum_out = {1'b1, {(psum_bw-1){1'b0}}};
            else
                sum_out = {1'b0, {(psum_bw-1){1'b1}}};
        end
    end

    always_comb begin
        act_out = act_in;
        case (mode)
            ACT_RELU: begin
                if (act_in[psum_bw-1])
                    act_out = '0;
            end
            ACT_LEAKY: begin
                if (act_in[psum_bw-1])
                    act_out = $signed(act_in) >>> LEAKY_SHIFT;
            end
            default: act_out = act_in;
        endcase
    end

endmodule

// File: rtl/sfu_acc_buf.sv
// rtl/sfu_acc_buf.sv - multi-pass psum accumulation buffer with activation drain and bypass
module sfu_acc_buf
    import sfu_acc_buf_pkg::*;
#(
    parameter int psum_bw     = 16,
    parameter int col         = 8,
    parameter int DEPTH       = 16,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic                   bypass_i,
    input  logic                   first_pass_i,
    input  logic                   last_pass_i,
    input  logic [1:0]             act_mode_i,
    input  logic [col*psum_bw-1:0] psum_in,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [col*psum_bw-1:0] psum_out,
    output logic                   sat_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int VW = col * psum_bw;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    sfu_state_t state, state_nxt;

    logic [VW-1:0] acc_mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] mem_raddr;
    logic [VW-1:0] mem_rdata;
    logic [VW-1:0] wr_data;
    logic [VW-1:0] act_data;
    logic [col-1:0] lane_sat;
    logic [1:0]    mode_q;
    logic          sat_q;
    logic          drain_tail;

    logic accept;
    logic acc_beat;
    logic byp_beat;
    logic tile_done;

    assign accept    = valid_i & ready_o;
    assign acc_beat  = accept & ~bypass_i;
    assign byp_beat  = accept & bypass_i;
    assign tile_done = acc_beat & last_pass_i & (wr_ptr == PTR_LAST);

    // Single read port: the accumulate read-modify-write and the drain never overlap.
    assign mem_raddr = (state == S_DRAIN) ? rd_ptr : wr_ptr;
    assign mem_rdata = acc_mem[mem_raddr];

    for (genvar k = 0; k < col; k++) begin : g_lane
        logic [psum_bw-1:0] lane_sum;

        sfu_lane_alu #(
            .psum_bw     (psum_bw),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_alu (
            .acc_a   (mem_rdata[k*psum_bw +: psum_bw]),
            .add_b   (psum_in[k*psum_bw +: psum_bw]),
            .act_in  (mem_rdata[k*psum_bw +: psum_bw]),
            .mode    (mode_q),
            .sum_out (lane_sum),
            .sat     (lane_sat[k]),
            .act_out (act_data[k*psum_bw +: psum_bw])
        );

        assign wr_data[k*psum_bw +: psum_bw] =
            first_pass_i ? psum_in[k*psum_bw +: psum_bw] : lane_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b1;
        case (state)
            S_IDLE: begin
                if (tile_done)
                    state_nxt = S_DRAIN;
                else if (acc_beat)
                    state_nxt = S_ACC;
            end
            S_ACC: begin
                if (tile_done)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                ready_o = 1'b0;
                if (drain_tail)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Buffer is plain RAM; a first-pass overwrite is what initialises it.
    always_ff @(posedge clk) begin
        if (acc_beat)
            acc_mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            mode_q <= ACT_NONE;
            sat_q  <= 1'b0;
        end else if (acc_beat) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (tile_done)
                mode_q <= act_mode_i;
            if (first_pass_i) begin
                if (wr_ptr == '0)
                    sat_q <= 1'b0;
            end else begin
                sat_q <= sat_q | (|lane_sat);
            end
        end
    end

    // The final drain cycle only retires the pipeline; it emits nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            drain_tail <= 1'b0;
            valid_o    <= 1'b0;
            psum_out   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (byp_beat) begin
                psum_out <= psum_in;
                valid_o  <= 1'b1;
            end else if (state == S_DRAIN) begin
                if (drain_tail) begin
                    drain_tail <= 1'b0;
                end else begin
                    psum_out <= act_data;
                    valid_o  <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                    if (rd_ptr == PTR_LAST)
                        drain_tail <= 1'b1;
                end
            end
        end
    end

    assign sat_o = sat_q;

endmodule
